// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: sequential word fetches over a req/ack handshake into a
// small {pc, instruction} FIFO drained by decode; a redirect flushes and refetches.
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  output logic                     instr_valid,
  output logic [31:0]              instr_out,
  output logic [31:0]              instr_pc,
  input  logic                     instr_ready,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   fill_count
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_e;

  state_e         state_q;
  logic [31:0]    fetch_pc_q;
  logic [31:0]    pending_pc_q;
  logic [AW-1:0]  rd_q, wr_q;
  logic [AW:0]    count_q, count_d;
  logic [31:0]    pc_mem  [DEPTH];
  logic [31:0]    ins_mem [DEPTH];
  logic           push, pop;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    push    = (state_q == REQ) && imem_ack && !redirect;
    pop     = (count_q != '0) && instr_ready && !redirect;
    count_d = count_q;
    if (redirect) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
      rd_q         <= '0;
      wr_q         <= '0;
      count_q      <= '0;
    end else begin
      count_q <= count_d;
      if (redirect) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + 1'b1;
        if (pop)  rd_q <= rd_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (redirect)             fetch_pc_q <= redirect_pc;
          else if (count_q < FULL)  state_q    <= REQ;
        end
        REQ: begin
          if (imem_ack) begin
            if (redirect) begin
              fetch_pc_q <= redirect_pc;
              state_q    <= IDLE;
            end else begin
              fetch_pc_q <= fetch_pc_q + 32'd4;
              if (count_d >= FULL) state_q <= IDLE;
            end
          end else if (redirect) begin
            // The outstanding fetch must still complete; park the target until it does.
            pending_pc_q <= redirect_pc;
            state_q      <= DISCARD;
          end
        end
        DISCARD: begin
          if (imem_ack) begin
            fetch_pc_q <= redirect ? redirect_pc : pending_pc_q;
            state_q    <= IDLE;
          end else if (redirect) begin
            pending_pc_q <= redirect_pc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the storage array is not reset; instr_valid gates its contents, so stale words never escape.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]  <= fetch_pc_q;
      ins_mem[wr_q] <= imem_rdata;
    end
  end

  // fetch_pc only advances on a completed fetch, so it is the stale address in DISCARD too.
  assign imem_req    = (state_q == REQ) || (state_q == DISCARD);
  assign imem_addr   = imem_req ? fetch_pc_q : 32'h0;
  assign instr_valid = (count_q != '0);
  assign instr_out   = instr_valid ? ins_mem[rd_q] : 32'h0;
  assign instr_pc    = instr_valid ? pc_mem[rd_q]  : 32'h0;
  assign fill_count  = count_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: cycle tables, directed corner cases and a
// randomized stream scored against an in-order pc sequence model.
module tb_instr_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready, redirect;
  logic [31:0] instr_out, instr_pc, redirect_pc;
  logic [2:0]  fill_count;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: the next pc decode must accept, and the memory responder's state.
  logic [31:0] exp_pc;
  int          n_pop;
  bit          mem_busy;
  int          mem_wait;
  logic [31:0] mem_addr;

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fill_count  (fill_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input bit rst, input bit rdy, input bit e_req, input logic [31:0] e_addr,
                     input bit e_valid, input logic [31:0] e_pc, input logic [31:0] e_ins,
                     input logic [2:0] e_cnt);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr;
    v.e_valid = e_valid; v.e_pc = e_pc; v.e_ins = e_ins; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  // Holds reset low for 3 cycles (checking the cleared outputs), releases it at a negedge.
  task automatic do_reset();
    reset = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0; mem_busy = 1'b0; mem_wait = 0;
    repeat (3) @(negedge clk);
    check("rst_req",   32'(imem_req),    32'd0);
    check("rst_addr",  imem_addr,        32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_ins",   instr_out,        32'h0);
    check("rst_pc",    instr_pc,         32'h0);
    check("rst_cnt",   32'(fill_count),  32'd0);
    reset  = 1'b1;
    exp_pc = RESET_PC;
  endtask

  // One cycle, entered and left at a negedge: invariants, memory responder, scoreboard.
  task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc, input int lat);
    check("cnt_bound", (fill_count <= 3'(DEPTH)) ? 32'd1 : 32'd0, 32'd1);
    check("valid_vs_cnt", 32'(instr_valid), (fill_count != 3'd0) ? 32'd1 : 32'd0);
    if (!instr_valid) begin
      check("empty_ins", instr_out, 32'h0);
      check("empty_pc",  instr_pc,  32'h0);
    end

    imem_ack = 1'b0;
    if (mem_busy) begin
      check("req_held",    32'(imem_req), 32'd1);
      check("addr_stable", imem_addr,     mem_addr);
    end else if (imem_req) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_wait = lat - 1;
    end
    if (mem_busy) begin
      if (mem_wait == 0) begin
        imem_ack = 1'b1;
        mem_busy = 1'b0;
      end else begin
        mem_wait--;
      end
    end
    imem_rdata = imem_ack ? mem_addr + 32'h100 : 32'hDEAD_BEEF;

    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    if (instr_valid && rdy && !redir) begin
      check("pop_pc",  instr_pc,  exp_pc);
      check("pop_ins", instr_out, exp_pc + 32'h100);
      exp_pc = exp_pc + 32'd4;
      n_pop++;
    end
    if (redir) exp_pc = rpc;

    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    exp_pc = RESET_PC; n_pop = 0; mem_busy = 1'b0; mem_wait = 0; mem_addr = 32'h0;

    // Streaming with ready=1: one instruction per cycle from cycle 2.
    add(1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0,   3'd0);
    add(1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0, 32'h0,   3'd0);
    add(1'b0, 1'b1, 1'b1, 32'h4,  1'b1, 32'h0, 32'h100, 3'd1);
    add(1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4, 32'h104, 3'd1);
    add(1'b0, 1'b1, 1'b1, 32'hC,  1'b1, 32'h8, 32'h108, 3'd1);
    // Backpressure: fill to DEPTH, stall, one pop frees a slot for fetch 0x10.
    add(1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0,   3'd0);
    add(1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0, 32'h0,   3'd0);
    add(1'b0, 1'b0, 1'b1, 32'h4,  1'b1, 32'h0, 32'h100, 3'd1);
    add(1'b0, 1'b0, 1'b1, 32'h8,  1'b1, 32'h0, 32'h100, 3'd2);
    add(1'b0, 1'b0, 1'b1, 32'hC,  1'b1, 32'h0, 32'h100, 3'd3);
    add(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0, 32'h100, 3'd4);
    add(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h4, 32'h104, 3'd3);
    add(1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h4, 32'h104, 3'd3);
    add(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h4, 32'h104, 3'd4);

    @(negedge clk);
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      check($sformatf("v%0d_req", i),   32'(imem_req),    32'(vecs[i].e_req));
      if (vecs[i].e_req) check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d_pc", i),    instr_pc,         vecs[i].e_pc);
      check($sformatf("v%0d_ins", i),   instr_out,        vecs[i].e_ins);
      check($sformatf("v%0d_cnt", i),   32'(fill_count),  32'(vecs[i].e_cnt));
      step(vecs[i].rdy, 1'b0, 32'h0, 1);
    end

    // Redirect while a slow fetch is outstanding: address held, data dropped, refetch at 0x40.
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1);
    check("dis_req0",  32'(imem_req), 32'd1);
    step(1'b0, 1'b0, 32'h0, 4);
    step(1'b0, 1'b1, 32'h40, 1);
    check("dis_req1",  32'(imem_req), 32'd1);
    check("dis_addr1", imem_addr,     32'h0);
    step(1'b0, 1'b0, 32'h0, 1);
    check("dis_addr2", imem_addr,     32'h0);
    step(1'b0, 1'b0, 32'h0, 1);
    check("dis_idle",  32'(imem_req),   32'd0);
    check("dis_cnt",   32'(fill_count), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1);
    check("dis_newreq",  32'(imem_req), 32'd1);
    check("dis_newaddr", imem_addr,     32'h40);
    step(1'b0, 1'b0, 32'h0, 1);
    check("dis_head_pc", instr_pc, 32'h40);
    step(1'b1, 1'b0, 32'h0, 1);

    // Redirect + ack + ready in one cycle with 2 entries held.
    do_reset();
    repeat (3) step(1'b0, 1'b0, 32'h0, 1);
    check("flush_pre_cnt",  32'(fill_count), 32'd2);
    check("flush_pre_addr", imem_addr,       32'h8);
    step(1'b1, 1'b1, 32'h80, 1);
    check("flush_valid", 32'(instr_valid), 32'd0);
    check("flush_cnt",   32'(fill_count),  32'd0);
    step(1'b0, 1'b0, 32'h0, 1);
    check("flush_req",   32'(imem_req), 32'd1);
    check("flush_addr",  imem_addr,     32'h80);
    step(1'b0, 1'b0, 32'h0, 1);
    check("flush_head",  instr_pc, 32'h80);
    step(1'b1, 1'b0, 32'h0, 1);

    // Asynchronous reset mid-REQ, away from any clock edge.
    do_reset();
    repeat (3) step(1'b0, 1'b0, 32'h0, 1);
    step(1'b0, 1'b0, 32'h0, 4);
    check("arst_pre_valid", 32'(instr_valid), 32'd1);
    check("arst_pre_req",   32'(imem_req),    32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_req",   32'(imem_req),    32'd0);
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_cnt",   32'(fill_count),  32'd0);
    do_reset();
    step(1'b1, 1'b0, 32'h0, 1);
    check("arst_restart", imem_addr, RESET_PC);
    repeat (4) step(1'b1, 1'b0, 32'h0, 1);

    // 20 fetches, random latency 1-4 and random ready: pcs 0..0x4C in order.
    do_reset();
    n_pop = 0;
    for (int cyc = 0; cyc < 2000 && n_pop < 20; cyc++)
      step(bit'($urandom_range(0, 1)), 1'b0, 32'h0, int'($urandom_range(1, 4)));
    check("stream_pops", n_pop, 32'd20);

    // Random redirects (including targets that wrap past 2^32 and unaligned ones).
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : $urandom;
      step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 15) == 0), tgt,
           int'($urandom_range(1, 4)));
    end
    n_pop = 0;
    repeat (40) step(1'b1, 1'b0, 32'h0, int'($urandom_range(1, 4)));
    check("drain_live", (n_pop >= 5) ? 32'd1 : 32'd0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
